// File: rtl/sensor_uart_tx_arbiter.sv
// sensor_uart_tx_arbiter
// Round-robin arbiter that shares one UART TX byte engine between the ADS1292
// ECG stream and the MPR121 touch stream. A packet is a header byte followed by
// the latched payload, MSB byte first, delivered over a valid/ready handshake.
// Optional build macro SENSOR_UART_TX_CHECKSUM_EN appends one XOR checksum byte
// (XOR of all payload bytes, header excluded) after the payload.
module sensor_uart_tx_arbiter #(
  parameter int unsigned ADS_BYTES = 9,
  parameter int unsigned MPR_BYTES = 2,
  parameter logic [7:0]  ADS_HDR   = 8'hA5,
  parameter logic [7:0]  MPR_HDR   = 8'h5A
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   ADS_REQ,
  input  logic [8*ADS_BYTES-1:0] ADS_DATA,
  output logic                   ADS_ACK,
  output logic                   ADS_DONE,
  input  logic                   MPR_REQ,
  input  logic [8*MPR_BYTES-1:0] MPR_DATA,
  output logic                   MPR_ACK,
  output logic                   MPR_DONE,
  output logic [7:0]             UART_TX_DATA,
  output logic                   UART_TX_VALID,
  input  logic                   UART_TX_READY,
  output logic                   BUSY
);

  localparam int unsigned MAXB  = (ADS_BYTES > MPR_BYTES) ? ADS_BYTES : MPR_BYTES;
  localparam int unsigned SH_W  = 8 * MAXB;
  localparam int unsigned CNT_W = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam logic [CNT_W-1:0] ADS_LAST = CNT_W'(ADS_BYTES - 1);
  localparam logic [CNT_W-1:0] MPR_LAST = CNT_W'(MPR_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
`ifdef SENSOR_UART_TX_CHECKSUM_EN
    CHK     = 3'd3,
`endif
    DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              src_q, src_d;           // 1 = MPR packet in flight
  logic              last_mpr_q, last_mpr_d; // 1 = MPR was served last
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              ads_ack_q, ads_ack_d;
  logic              mpr_ack_q, mpr_ack_d;
  logic              ads_done_q, ads_done_d;
  logic              mpr_done_q, mpr_done_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              pick_mpr;
  logic              last_byte;
  logic              load_byte;
  logic              finish_pkt;
  logic [7:0]        top_byte;
  logic [SH_W-1:0]   ads_aligned;
  logic [SH_W-1:0]   mpr_aligned;

  // Payloads are left-aligned so the MSB byte always sits at the top of the shifter.
  assign ads_aligned = SH_W'(ADS_DATA) << (SH_W - 8 * ADS_BYTES);
  assign mpr_aligned = SH_W'(MPR_DATA) << (SH_W - 8 * MPR_BYTES);
  assign top_byte    = shreg_q[SH_W-1 -: 8];
  assign accept      = tx_valid_q & UART_TX_READY;
  assign pick_mpr    = MPR_REQ & (~ADS_REQ | ~last_mpr_q);
  assign last_byte   = src_q ? (cnt_q == MPR_LAST) : (cnt_q == ADS_LAST);

`ifdef SENSOR_UART_TX_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;

  // Running XOR of every payload byte as it is placed on the bus.
  always_comb begin
    chk_d = chk_q;
    if (state_q == IDLE) chk_d = 8'h00;
    else if (load_byte)  chk_d = chk_q ^ top_byte;
  end

  // Checksum accumulator; cleared while idle, so no reset is needed.
  always_ff @(posedge CLK) begin
    chk_q <= chk_d;
  end
`endif

  // Next-state and registered-output logic for the packet framer.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    src_d      = src_q;
    last_mpr_d = last_mpr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    ads_ack_d  = 1'b0;
    mpr_ack_d  = 1'b0;
    ads_done_d = 1'b0;
    mpr_done_d = 1'b0;
    busy_d     = busy_q;
    load_byte  = 1'b0;
    finish_pkt = 1'b0;

    case (state_q)
      IDLE: begin
        if (ADS_REQ || MPR_REQ) begin
          src_d      = pick_mpr;
          shreg_d    = pick_mpr ? mpr_aligned : ads_aligned;
          ads_ack_d  = ~pick_mpr;
          mpr_ack_d  = pick_mpr;
          busy_d     = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = pick_mpr ? MPR_HDR : ADS_HDR;
          cnt_d      = '0;
          state_d    = HDR;
        end
      end
      HDR: begin
        if (accept) begin
          load_byte = 1'b1;
          cnt_d     = '0;
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          if (last_byte) begin
`ifdef SENSOR_UART_TX_CHECKSUM_EN
            tx_data_d = chk_q;
            state_d   = CHK;
`else
            finish_pkt = 1'b1;
`endif
          end else begin
            load_byte = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef SENSOR_UART_TX_CHECKSUM_EN
      CHK: begin
        if (accept) finish_pkt = 1'b1;
      end
`endif
      DONE: begin
        busy_d     = 1'b0;
        last_mpr_d = src_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_byte) begin
      tx_data_d = top_byte;
      shreg_d   = shreg_q << 8;
    end

    if (finish_pkt) begin
      tx_valid_d = 1'b0;
      ads_done_d = ~src_q;
      mpr_done_d = src_q;
      state_d    = DONE;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      src_q      <= 1'b0;
      last_mpr_q <= 1'b1;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      ads_ack_q  <= 1'b0;
      mpr_ack_q  <= 1'b0;
      ads_done_q <= 1'b0;
      mpr_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_q      <= src_d;
      last_mpr_q <= last_mpr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ads_ack_q  <= ads_ack_d;
      mpr_ack_q  <= mpr_ack_d;
      ads_done_q <= ads_done_d;
      mpr_done_q <= mpr_done_d;
      busy_q     <= busy_d;
    end
  end

  // Payload shifter; contents are only meaningful after a grant loads it.
  always_ff @(posedge CLK) begin
    shreg_q <= shreg_d;
  end

  assign UART_TX_DATA  = tx_data_q;
  assign UART_TX_VALID = tx_valid_q;
  assign ADS_ACK       = ads_ack_q;
  assign MPR_ACK       = mpr_ack_q;
  assign ADS_DONE      = ads_done_q;
  assign MPR_DONE      = mpr_done_q;
  assign BUSY          = busy_q;

endmodule
